// File: rtl/ifu_line_fetch_pkg.sv
// Shared types and constants for the IFU line-fetch front end.
package ifu_line_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_AR    = 2'd1,
    ST_FILL  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] FLASH_BASE = 32'h3000_0000;
  localparam logic [31:0] SDRAM_BASE = 32'h8000_0000;

endpackage

// File: rtl/ifu_line_fetch.sv
// One-line instruction buffer in front of an AXI4 read master: 1-cycle hits,
// one INCR burst per miss, optional forwarding of the requested beat.
module ifu_line_fetch
  import ifu_line_fetch_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter bit BYPASS     = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              flush,
  output logic              inst_valid,
  output logic [31:0]       inst_data,
  output logic              inst_err,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  input  logic              rvalid,
  output logic              rready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W = IDX_W + 2;
  localparam int TAG_W = ADDR_W - OFF_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  state_e            state_q, state_d;
  logic              line_valid_q, line_valid_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              err_sticky_q, err_sticky_d;
  logic              full_q, full_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              inst_valid_q, inst_valid_d;
  logic              inst_err_q, inst_err_d;
  logic [31:0]       inst_data_q, inst_data_d;
  logic [31:0]       line_q [LINE_WORDS];
  logic [31:0]       line_d [LINE_WORDS];

  logic [TAG_W-1:0]  pc_tag;
  logic [IDX_W-1:0]  pc_idx;
  logic              beat, berr, hit_now, missed;

  assign pc_tag  = pc_addr[ADDR_W-1:OFF_W];
  assign pc_idx  = pc_addr[OFF_W-1:2];
  assign beat    = rvalid & rready_q;
  assign berr    = err_sticky_q | (rresp != RESP_OKAY);
  // full_q marks that the last slot is written; further beats are overflow.
  assign hit_now = ~full_q & (beat_cnt_q == idx_q);
  assign missed  = ~full_q & (beat_cnt_q < idx_q);

  assign pc_ready   = (state_q == ST_IDLE) & ~flush;
  assign arvalid    = arvalid_q;
  assign araddr     = {tag_q, {OFF_W{1'b0}}};
  assign arlen      = 8'(LINE_WORDS - 1);
  assign rready     = rready_q;
  assign inst_valid = inst_valid_q;
  assign inst_err   = inst_err_q;
  assign inst_data  = inst_data_q;

  always_comb begin
    state_d      = state_q;
    line_valid_d = line_valid_q;
    tag_d        = tag_q;
    idx_d        = idx_q;
    beat_cnt_d   = beat_cnt_q;
    err_sticky_d = err_sticky_q;
    full_d       = full_q;
    arvalid_d    = arvalid_q;
    inst_valid_d = 1'b0;
    inst_err_d   = 1'b0;
    inst_data_d  = inst_data_q;
    line_d       = line_q;

    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          line_valid_d = 1'b0;
        end else if (pc_valid) begin
          if (pc_addr[1:0] != 2'b00) begin
            inst_valid_d = 1'b1;
            inst_err_d   = 1'b1;
            inst_data_d  = 32'h0;
          end else if (line_valid_q && (pc_tag == tag_q)) begin
            inst_valid_d = 1'b1;
            inst_data_d  = line_q[pc_idx];
          end else begin
            state_d      = ST_AR;
            line_valid_d = 1'b0;
            tag_d        = pc_tag;
            idx_d        = pc_idx;
            arvalid_d    = 1'b1;
          end
        end
      end

      ST_AR: begin
        if (arready) begin
          arvalid_d    = 1'b0;
          beat_cnt_d   = '0;
          err_sticky_d = 1'b0;
          full_d       = 1'b0;
          state_d      = flush ? ST_DRAIN : ST_FILL;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end

      ST_FILL: begin
        if (beat) begin
          err_sticky_d = berr;
          if (!full_q) begin
            line_d[beat_cnt_q] = rdata;
            if (beat_cnt_q == LAST_IDX) full_d = 1'b1;
            else                        beat_cnt_d = beat_cnt_q + 1'b1;
          end
          if (flush) begin
            // A flush on the final beat has nothing left to drain.
            state_d = rlast ? ST_IDLE : ST_DRAIN;
          end else begin
            if (BYPASS && hit_now) begin
              inst_valid_d = 1'b1;
              inst_err_d   = berr;
              inst_data_d  = rdata;
            end
            if (rlast) begin
              state_d      = ST_IDLE;
              line_valid_d = ~berr & ~full_q & (beat_cnt_q == LAST_IDX);
              if (missed) begin
                inst_valid_d = 1'b1;
                inst_err_d   = 1'b1;
                inst_data_d  = 32'h0;
              end else if (!BYPASS) begin
                inst_valid_d = 1'b1;
                inst_err_d   = berr;
                inst_data_d  = hit_now ? rdata : line_q[idx_q];
              end
            end
          end
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        line_valid_d = 1'b0;
        if (arvalid_q) begin
          if (arready) arvalid_d = 1'b0;
        end else if (beat && rlast) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    rready_d = (state_d == ST_FILL) || (state_d == ST_DRAIN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      line_valid_q <= 1'b0;
      tag_q        <= '0;
      idx_q        <= '0;
      beat_cnt_q   <= '0;
      err_sticky_q <= 1'b0;
      full_q       <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_err_q   <= 1'b0;
      inst_data_q  <= 32'h0;
      for (int i = 0; i < LINE_WORDS; i++) line_q[i] <= 32'h0;
    end else begin
      state_q      <= state_d;
      line_valid_q <= line_valid_d;
      tag_q        <= tag_d;
      idx_q        <= idx_d;
      beat_cnt_q   <= beat_cnt_d;
      err_sticky_q <= err_sticky_d;
      full_q       <= full_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      inst_valid_q <= inst_valid_d;
      inst_err_q   <= inst_err_d;
      inst_data_q  <= inst_data_d;
      line_q       <= line_d;
    end
  end

endmodule
